// File: rtl/dmem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data memory (slave).
// Latency: none, signal bundle only.
// Backpressure: stall from the slave holds the master's request in place.
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        misalign_err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, stall, misalign_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, stall, misalign_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-array data memory for the MEM stage; posted stores optional via DMEM_POSTED_WRITE_EN.
// Latency: ready pulses LATENCY cycles after acceptance (posted store: next cycle, drains after LATENCY).
// Backpressure: stall is raised from acceptance until the response cycle; the pipeline holds its request.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op_wr;
    logic            op_mis;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_dat;
    logic [31:0]     rdata_q;
    logic            ready_q;
    logic            mis_q;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            req_wr;
    logic            req_mis;
    logic [AW-1:0]   req_idx;
    logic            absorb;
    logic            accept;

    logic            wb_vld;
    logic            wb_drain;
    logic [AW-1:0]   wb_idx;
    logic [31:0]     wb_dat;

    logic            mem_we;
    logic [AW-1:0]   mem_widx;
    logic [31:0]     mem_wdat;

    logic            unused_addr;

    assign req     = bus.mem_read | bus.mem_write;
    assign req_wr  = bus.mem_write;
    assign req_mis = |bus.addr[1:0];
    assign req_idx = bus.addr[AW+1:2];
    assign unused_addr = &{1'b0, bus.addr[31:AW+2]};

`ifdef DMEM_POSTED_WRITE_EN
    logic [CW-1:0] wb_cnt;

    // Aligned stores seen with an empty buffer skip the FSM entirely.
    assign absorb   = (state == IDLE) && req && req_wr && !req_mis && !wb_vld;
    assign wb_drain = wb_vld && (wb_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld <= 1'b0;
            wb_cnt <= '0;
            wb_idx <= '0;
            wb_dat <= '0;
        end else if (absorb) begin
            wb_vld <= 1'b1;
            wb_cnt <= CW'(LATENCY - 1);
            wb_idx <= req_idx;
            wb_dat <= bus.wdata;
        end else if (wb_vld) begin
            if (wb_cnt == '0) begin
                wb_vld <= 1'b0;
            end else begin
                wb_cnt <= wb_cnt - 1'b1;
            end
        end
    end
`else
    assign absorb   = 1'b0;
    assign wb_vld   = 1'b0;
    assign wb_drain = 1'b0;
    assign wb_idx   = '0;
    assign wb_dat   = '0;
`endif

    // A pending posted write blocks new requests until it has drained.
    assign accept = (state == IDLE) && req && !wb_vld && !absorb;

    assign bus.stall = rst_n && (((state == IDLE) && req && !absorb) || (state == BUSY));
    assign bus.rdata        = rdata_q;
    assign bus.ready        = ready_q;
    assign bus.misalign_err = mis_q;

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = op_idx;
        mem_wdat = op_dat;
        if (wb_drain) begin
            mem_we   = 1'b1;
            mem_widx = wb_idx;
            mem_wdat = wb_dat;
        end else if ((state == RESP) && op_wr && !op_mis) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            op_mis  <= 1'b0;
            op_idx  <= '0;
            op_dat  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (absorb) begin
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        op_wr  <= req_wr;
                        op_mis <= req_mis;
                        op_idx <= req_idx;
                        op_dat <= bus.wdata;
                        if (LATENCY == 1) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            mis_q   <= req_mis;
                            if (!req_wr && !req_mis) begin
                                rdata_q <= mem[req_idx];
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    // Response registers load on the edge entering RESP.
                    if (cnt == CW'(1)) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        mis_q   <= op_mis;
                        if (!op_wr && !op_mis) begin
                            rdata_q <= mem[op_idx];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model.
// Latency: checks ready timing and stall shape per access. Backpressure: holds requests while stall=1.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int LATENCY = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
    endtask

    // One pipeline access: drive, hold while stalled, check the response against the model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit          mis;
        int          idx;
        int          n;
        int          stall_lo;
        bit          got_rdy;
        logic [31:0] exp_rd;
        bit          rd_known;
        mis = (a[1:0] != 2'b00);
        idx = int'(a[AW+1:2]);
        exp_rd   = '0;
        rd_known = 1'b1;
        if (!wr && !mis) begin
            exp_rd   = ref_mem[idx];
            rd_known = ref_known[idx];
        end
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        #1;
        stall_lo = (bus.stall == 1'b1) ? 0 : 1;
        got_rdy  = 1'b0;
        n        = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                n       = c;
                got_rdy = 1'b1;
                break;
            end
            if (!bus.stall) stall_lo++;
        end
        if (!got_rdy) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
`ifndef DMEM_POSTED_WRITE_EN
            check("latency", 32'(n), 32'(LATENCY));
            check("stall_low_before_ready", 32'(stall_lo), 32'd0);
`endif
            check("stall_in_resp", {31'd0, bus.stall}, 32'd0);
            check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, mis});
            if (rd_known) check("rdata", bus.rdata, exp_rd);
        end
        idle_bus();
        if (wr && !mis) begin
            ref_mem[idx]   = d;
            ref_known[idx] = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", {31'd0, bus.ready}, 32'd0);
        check("idle_stall", {31'd0, bus.stall}, 32'd0);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h400, 32'h12345678);
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h13, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b1, 1'b1, 32'h14, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h14, 32'h0);

        // Reset during an in-flight store must leave the array untouched.
        access(1'b0, 1'b1, 32'h20, 32'h11111111);
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.addr      = 32'h20;
        bus.wdata     = 32'hCAFEF00D;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, bus.stall}, 32'd0);
        check("midrst_ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);
        check("midrst_stall_held", {31'd0, bus.stall}, 32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h20, 32'h0);

`ifdef DMEM_POSTED_WRITE_EN
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.addr      = 32'h30;
        bus.wdata     = 32'hA5A5A5A5;
        #1;
        check("posted_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        check("posted_ready", {31'd0, bus.ready}, 32'd1);
        ref_mem[12]   = 32'hA5A5A5A5;
        ref_known[12] = 1'b1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        #1;
        check("posted_load_stall", {31'd0, bus.stall}, 32'd1);
        begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("posted_load_ready", {31'd0, got}, 32'd1);
            check("posted_load_rdata", bus.rdata, 32'hA5A5A5A5);
        end
        idle_bus();
`endif

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          op;
            int          gap;
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d   = $urandom;
            op  = $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            access(op != 1, (op == 1) || (op == 2), a, d);
            repeat (gap) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
